// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU / multiply-divide unit.
package alu_pkg;

    localparam int unsigned FW = 4;

    localparam logic [FW-1:0] FN_ADD = 4'd0;
    localparam logic [FW-1:0] FN_SUB = 4'd1;
    localparam logic [FW-1:0] FN_AND = 4'd2;
    localparam logic [FW-1:0] FN_NOR = 4'd3;
    localparam logic [FW-1:0] FN_SLL = 4'd4;
    localparam logic [FW-1:0] FN_SRL = 4'd5;
    localparam logic [FW-1:0] FN_SRA = 4'd6;
    localparam logic [FW-1:0] FN_LHB = 4'd7;
    localparam logic [FW-1:0] FN_MUL = 4'd8;
    localparam logic [FW-1:0] FN_DIV = 4'd9;
    localparam logic [FW-1:0] FN_REM = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Saturation limits for a dw-bit two's-complement value, zero-extended to 64 bits.
    function automatic logic [63:0] max_pos(input int unsigned dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] max_neg(input int unsigned dw);
        return 64'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/result bundle between the EX-stage control and the ALU/MDU.
interface alu_mdu_if
    import alu_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned SW = $clog2(DW)
);
    logic          start;
    logic [FW-1:0] func;
    logic [DW-1:0] src0;
    logic [DW-1:0] src1;
    logic [SW-1:0] shamt;
    logic          flush;
    logic          busy;
    logic          res_vld;
    logic [DW-1:0] dst;
    logic          ov;
    logic          zr;
    logic          neg;
    logic          dz;

    modport master (
        output start, func, src0, src1, shamt, flush,
        input  busy, res_vld, dst, ov, zr, neg, dz
    );

    modport slave (
        input  start, func, src0, src1, shamt, flush,
        output busy, res_vld, dst, ov, zr, neg, dz
    );
endinterface

// File: rtl/alu_mdu_muldiv_iter.sv
// Unsigned iterative engine: DW shift-add (multiply) or restoring-subtract (divide) steps.
module muldiv_iter #(
    parameter int unsigned DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_go,
    input  logic            i_flush,
    input  logic            i_div,
    input  logic [DW-1:0]   i_mag0,
    input  logic [DW-1:0]   i_mag1,
    output logic [2*DW-1:0] o_raw,
    output logic            o_done_c
);
    localparam int unsigned CW = $clog2(DW);

    // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
    logic [2*DW-1:0] r_acc;
    logic [2*DW-1:0] w_acc_nxt;
    logic [DW-1:0]   r_b;
    logic            r_div;
    logic            r_run;
    logic [CW-1:0]   r_cnt;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_shl;
    logic [DW:0]     w_diff;

    always_comb begin
        w_sum  = {1'b0, r_acc[2*DW-1:DW]} + {1'b0, (r_acc[0] ? r_b : {DW{1'b0}})};
        w_shl  = {r_acc[2*DW-1:DW], r_acc[DW-1]};
        w_diff = w_shl - {1'b0, r_b};
        if (!r_div)
            w_acc_nxt = {w_sum, r_acc[DW-1:1]};
        else if (w_diff[DW])
            w_acc_nxt = {w_shl[DW-1:0], r_acc[DW-2:0], 1'b0};
        else
            w_acc_nxt = {w_diff[DW-1:0], r_acc[DW-2:0], 1'b1};
    end

    assign o_done_c = r_run && (r_cnt == CW'(DW - 1));
    assign o_raw    = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_go) begin
            r_acc <= {{DW{1'b0}}, (i_div ? i_mag1 : i_mag0)};
            r_b   <= i_div ? i_mag0 : i_mag1;
            r_div <= i_div;
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_run <= 1'b0;
        end else if (r_run) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (o_done_c) r_run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// Saturating EX-stage ALU with an iterative signed MUL/DIV/REM path and registered results/flags.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned SW = $clog2(DW)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mdu_if.slave bus
);
    localparam int unsigned HW  = DW / 2;
    localparam int unsigned DW2 = 2 * DW;
    localparam logic [DW-1:0] MAXPOS = DW'(max_pos(DW));
    localparam logic [DW-1:0] MAXNEG = DW'(max_neg(DW));

    state_e          r_state, w_state_nxt;
    logic [FW-1:0]   r_func;
    logic            r_s0, r_s1;
    logic [DW-1:0]   r_dst;
    logic            r_ov, r_zr, r_neg, r_dz, r_vld, r_busy;

    logic            w_go, w_load, w_rsvd, w_ov_nxt, w_dz_nxt;
    logic [DW-1:0]   w_dst_nxt;
    logic            w_is_md, w_is_dr, w_src0_zero;
    logic [DW-1:0]   w_mag0, w_mag1;
    logic [SW-1:0]   w_shamt;
    logic [DW:0]     w_add, w_sub;
    logic signed [DW-1:0] w_sra;
    logic [DW-1:0]   w_sc_dst;
    logic            w_sc_ov, w_sc_dz, w_sc_rsvd;
    logic [DW-1:0]   w_md_dst;
    logic            w_md_ov, w_md_negres;
    logic [DW2-1:0]  w_raw;
    logic [DW-1:0]   w_lo, w_hi;
    logic            w_done_c;

    function automatic logic [DW:0] sat_sum(input logic [DW:0] x);
        if (x[DW] != x[DW-1]) return {1'b1, (x[DW] ? MAXNEG : MAXPOS)};
        return {1'b0, x[DW-1:0]};
    endfunction

    assign w_is_dr     = (bus.func == FN_DIV) || (bus.func == FN_REM);
    assign w_is_md     = (bus.func == FN_MUL) || w_is_dr;
    assign w_src0_zero = (bus.src0 == '0);
    assign w_mag0      = bus.src0[DW-1] ? -bus.src0 : bus.src0;
    assign w_mag1      = bus.src1[DW-1] ? -bus.src1 : bus.src1;
    assign w_shamt     = bus.shamt;
    assign w_add       = {bus.src1[DW-1], bus.src1} + {bus.src0[DW-1], bus.src0};
    assign w_sub       = {bus.src1[DW-1], bus.src1} - {bus.src0[DW-1], bus.src0};
    assign w_sra       = $signed(bus.src1) >>> w_shamt;

    muldiv_iter #(.DW(DW)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_go    (w_go),
        .i_flush (bus.flush),
        .i_div   (bus.func != FN_MUL),
        .i_mag0  (w_mag0),
        .i_mag1  (w_mag1),
        .o_raw   (w_raw),
        .o_done_c(w_done_c)
    );

    // Single-cycle results, including the divide-by-zero shortcut.
    always_comb begin
        w_sc_dst  = '0;
        w_sc_ov   = 1'b0;
        w_sc_dz   = 1'b0;
        w_sc_rsvd = 1'b0;
        case (bus.func)
            FN_ADD: {w_sc_ov, w_sc_dst} = sat_sum(w_add);
            FN_SUB: {w_sc_ov, w_sc_dst} = sat_sum(w_sub);
            FN_AND: w_sc_dst = bus.src1 & bus.src0;
            FN_NOR: w_sc_dst = ~(bus.src1 | bus.src0);
            FN_SLL: w_sc_dst = bus.src1 << w_shamt;
            FN_SRL: w_sc_dst = bus.src1 >> w_shamt;
            FN_SRA: w_sc_dst = w_sra;
            FN_LHB: w_sc_dst = {bus.src1[HW-1:0], bus.src0[HW-1:0]};
            FN_MUL: w_sc_dst = '0;
            FN_DIV: begin
                w_sc_dz  = 1'b1;
                w_sc_ov  = 1'b1;
                w_sc_dst = bus.src1[DW-1] ? MAXNEG : MAXPOS;
            end
            FN_REM: begin
                w_sc_dz  = 1'b1;
                w_sc_ov  = 1'b1;
                w_sc_dst = bus.src1;
            end
            default: w_sc_rsvd = 1'b1;
        endcase
    end

    assign w_lo        = w_raw[DW-1:0];
    assign w_hi        = w_raw[DW2-1:DW];
    assign w_md_negres = r_s0 ^ r_s1;

    // Sign correction and saturation of the unsigned engine result.
    always_comb begin
        w_md_dst = '0;
        w_md_ov  = 1'b0;
        case (r_func)
            FN_MUL: begin
                if (w_md_negres && (w_raw > DW2'(MAXNEG))) begin
                    w_md_dst = MAXNEG;
                    w_md_ov  = 1'b1;
                end else if (!w_md_negres && (w_raw > DW2'(MAXPOS))) begin
                    w_md_dst = MAXPOS;
                    w_md_ov  = 1'b1;
                end else begin
                    w_md_dst = w_md_negres ? -w_lo : w_lo;
                end
            end
            FN_DIV: begin
                if (!w_md_negres && (w_lo > MAXPOS)) begin
                    w_md_dst = MAXPOS;
                    w_md_ov  = 1'b1;
                end else begin
                    w_md_dst = w_md_negres ? -w_lo : w_lo;
                end
            end
            FN_REM:  w_md_dst = r_s1 ? -w_hi : w_hi;
            default: w_md_dst = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_load      = 1'b0;
        w_dst_nxt   = w_sc_dst;
        w_ov_nxt    = w_sc_ov;
        w_dz_nxt    = w_sc_dz;
        w_rsvd      = w_sc_rsvd;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_is_md && !(w_is_dr && w_src0_zero)) begin
                        w_go        = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.flush)     w_state_nxt = ST_IDLE;
                else if (w_done_c) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (!bus.flush) begin
                    w_load    = 1'b1;
                    w_dst_nxt = w_md_dst;
                    w_ov_nxt  = w_md_ov;
                    w_dz_nxt  = 1'b0;
                    w_rsvd    = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand signs are needed again at DONE for sign correction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func <= '0;
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
        end else if (w_go) begin
            r_func <= bus.func;
            r_s0   <= bus.src0[DW-1];
            r_s1   <= bus.src1[DW-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst  <= '0;
            r_ov   <= 1'b0;
            r_zr   <= 1'b0;
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
            r_vld  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_vld  <= w_load;
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_load) begin
                r_dst <= w_dst_nxt;
                r_ov  <= w_ov_nxt;
                r_dz  <= w_dz_nxt;
                r_zr  <= !w_rsvd && (w_dst_nxt == '0);
                r_neg <= w_dst_nxt[DW-1];
            end
        end
    end

    assign bus.dst     = r_dst;
    assign bus.ov      = r_ov;
    assign bus.zr      = r_zr;
    assign bus.neg     = r_neg;
    assign bus.dz      = r_dz;
    assign bus.res_vld = r_vld;
    assign bus.busy    = r_busy;
endmodule
